// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the control path and the multiply/divide unit.
// The control path drives the request; the unit returns status and the HI/LO pair.
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO: one shift-add or
// restoring-divide step per cycle on magnitudes, signs applied in FINISH.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  mips_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

  state_e             state;
  logic               busy, done, div_zero;
  logic [WIDTH-1:0]   hi, lo;
  logic [CNT_W-1:0]   cnt;
  logic               is_div, dz, neg_q, neg_r;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;

  // Operand conditioning at acceptance: only MULT and DIV treat inputs as signed.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign a_neg     = is_signed & bus.src_a[WIDTH-1];
  assign b_neg     = is_signed & bus.src_b[WIDTH-1];
  assign abs_a     = a_neg ? -bus.src_a : bus.src_a;
  assign abs_b     = b_neg ? -bus.src_b : bus.src_b;

  // Multiply step: conditionally add the multiplicand into the upper half, shift right.
  logic [WIDTH:0] mul_addend, mul_sum;
  assign mul_addend = acc[0] ? {1'b0, mag_a} : '0;
  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_addend;

  // Divide step: shift the next dividend bit in, subtract if the divisor fits.
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fits;
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_fits  = div_shift >= {2'b00, mag_b};
  assign div_diff  = div_shift[WIDTH:0] - {1'b0, mag_b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      dz       <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mag_a    <= '0;
      mag_b    <= '0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
    end else begin
      // NOTE: non-blocking everywhere here, so every right-hand side sees the
      // pre-edge value and the later assignment to the same register wins.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_MTHI: begin
                hi       <= bus.src_a;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              OP_MTLO: begin
                lo       <= bus.src_a;
                done     <= 1'b1;
                div_zero <= 1'b0;
              end
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                busy     <= 1'b1;
                div_zero <= 1'b0;
                cnt      <= '0;
                is_div   <= bus.op[1];
                mag_a    <= abs_a;
                mag_b    <= abs_b;
                acc      <= {{WIDTH{1'b0}}, abs_b};
                rem      <= '0;
                quo      <= abs_a;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                dz       <= 1'b0;
                state    <= RUN;
                // Zero divisor: preload the architectural result and skip iterating.
                if (bus.op[1] && (bus.src_b == '0)) begin
                  dz    <= 1'b1;
                  neg_q <= 1'b0;
                  neg_r <= 1'b0;
                  rem   <= {1'b0, bus.src_a};
                  quo   <= '1;
                  state <= FINISH;
                end
              end
              default: ;
            endcase
          end
        end

        RUN: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            rem <= div_fits ? div_diff : div_shift[WIDTH:0];
            quo <= {quo[WIDTH-2:0], div_fits};
          end else begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end
          if (cnt == LAST_ITER) state <= FINISH;
        end

        FINISH: begin
          if (is_div) begin
            lo <= neg_q ? -quo : quo;
            hi <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
          div_zero <= dz;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = div_zero;
  assign bus.hi       = hi;
  assign bus.lo       = lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv: hand-computed results, latency, busy span,
// single done pulse, ignored requests, divide by zero and mid-operation reset.
module tb_mips_muldiv;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request and follow it to done; inputs driven and outputs sampled on negedges.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int lat, input int busy_exp,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input bit inject);
    int          n;
    int          bcnt;
    logic [31:0] prev_hi;
    prev_hi = bus.hi;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    n    = 0;
    bcnt = 0;
    while (!bus.done && n < 60) begin
      if (bus.busy) bcnt++;
      if (inject && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.src_a = 32'hDEADBEEF;
        check({tag, "_hi_stable"}, 64'(bus.hi), 64'(prev_hi));
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"},   64'(n), 64'(lat));
    check({tag, "_busy_span"}, 64'(bcnt), 64'(busy_exp));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_hi"},        64'(bus.hi), 64'(ehi));
    check({tag, "_lo"},        64'(bus.lo), 64'(elo));
    check({tag, "_div_zero"},  64'(bus.div_zero), 64'(edz));
    @(negedge clk);
    check({tag, "_one_done"},  64'(bus.done), 64'd0);
  endtask

  initial begin
    int n_done;
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'b000;
    bus.src_a  = '0;
    bus.src_b  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_hi",       64'(bus.hi), 64'd0);
    check("rst_lo",       64'(bus.lo), 64'd0);
    check("rst_busy",     64'(bus.busy), 64'd0);
    check("rst_done",     64'(bus.done), 64'd0);
    check("rst_div_zero", 64'(bus.div_zero), 64'd0);

    run_op("mthi",  3'b100, 32'h6, 32'h0, 0, 0, 32'h6, 32'h0, 1'b0, 1'b0);
    run_op("mtlo",  3'b101, 32'h6, 32'h0, 0, 0, 32'h6, 32'h6, 1'b0, 1'b0);
    run_op("divu",  3'b011, 32'h11111111, 32'h00000088, 33, 33,
           32'h00000011, 32'h00202020, 1'b0, 1'b0);
    run_op("multu", 3'b001, 32'h11111111, 32'h00000088, 33, 33,
           32'h00000009, 32'h11111108, 1'b0, 1'b1);
    run_op("div_neg7_2", 3'b010, 32'hFFFFFFF9, 32'h00000002, 33, 33,
           32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("mult_neg3_5", 3'b000, 32'hFFFFFFFD, 32'h00000005, 33, 33,
           32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
    run_op("mult_min_sq", 3'b000, 32'h80000000, 32'h80000000, 33, 33,
           32'h40000000, 32'h00000000, 1'b0, 1'b0);
    run_op("div_min_m1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 33, 33,
           32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op("divu_by0", 3'b011, 32'd10, 32'd0, 1, 1,
           32'd10, 32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("multu_10_5", 3'b001, 32'd10, 32'd5, 33, 33,
           32'd0, 32'd50, 1'b0, 1'b0);

    // Reserved op code must leave every output alone.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.src_a = 32'h12345678;
    bus.src_b = 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    check("op110_done", 64'(bus.done), 64'd0);
    check("op110_busy", 64'(bus.busy), 64'd0);
    check("op110_hi",   64'(bus.hi), 64'd0);
    check("op110_lo",   64'(bus.lo), 64'd50);
    @(negedge clk);
    check("op110_done_late", 64'(bus.done), 64'd0);

    // Abort a MULTU at E10 with an asynchronous reset.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.src_a = 32'h0000FFFF;
    bus.src_b = 32'h00000003;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi",   64'(bus.hi), 64'd0);
    check("abort_lo",   64'(bus.lo), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_done  = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", 64'(n_done), 64'd0);
    check("abort_lo_after", 64'(bus.lo), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Multi-cycle multiply/divide unit owning the HI/LO register pair. It executes the MULT/MULTU/DIV/DIVU/MTHI/MTLO operations that the single-cycle `mips_alu` currently handles combinationally. It sits beside the ALU: the control path issues a request with a start/busy handshake, and MFHI/MFLO read the `hi`/`lo` outputs directly.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the iteration count equals `WIDTH`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled on the rising edge.
- `op` in 3: operation select. 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. Codes 110 and 111 are ignored (no state change, no `done`).
- `src_a` in 32: multiplicand, dividend, or MTHI/MTLO data.
- `src_b` in 32: multiplier or divisor.
- `busy` out 1: iterative operation in progress; new requests are ignored.
- `done` out 1: one-cycle pulse; `hi`/`lo` hold the new result in the same cycle.
- `div_zero` out 1: set with `done` when a DIV/DIVU divisor is 0; held until the next accepted request.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, RUN, FINISH.
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, iteration counter 0.
- Request acceptance: accepted only when `start`=1 in IDLE. In RUN and FINISH, `start` is ignored and has no side effects.
- MTHI/MTLO: `hi` (or `lo`) ← `src_a` at the accepting edge, `done`=1 the next cycle, `busy` never asserts, the other register is untouched, and `div_zero` is cleared.

**Mult/div acceptance (IDLE → RUN):**
- Latch the operand magnitudes; signed ops take two's-complement absolute values.
- Latch the result signs:
  - product sign = sign(a) XOR sign(b);
  - quotient sign = sign(a) XOR sign(b);
  - remainder sign = sign(a).
- Clear the counter and clear `div_zero`.

**Divide by zero:** if the op is DIV/DIVU and `src_b`=0, go directly to FINISH with no iterations. Result: `hi` ← `src_a`, `lo` ← 32'hFFFFFFFF, `div_zero`=1.

**RUN, one iteration per cycle, 32 iterations:**
- Multiply: shift-add into a 64-bit unsigned accumulator.
- Divide: restoring division with a 33-bit partial remainder and a 32-bit quotient shift register.
- After the 32nd iteration, go to FINISH.

**FINISH (one cycle):**
- Apply the latched signs and write `hi`/`lo`.
  - Multiply: {`hi`,`lo`} = 64-bit product.
  - Divide: `lo` = quotient, `hi` = remainder.
- Pulse `done`=1 and return to IDLE.

**Arithmetic rules:**
- Signed division truncates toward zero.
- DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (natural wrap, no flag).
- MULT of 0x80000000 × 0x80000000 gives 64'h4000_0000_0000_0000.

**Reset mid-operation:** an asynchronous abort to the reset values; the partial result is discarded and no `done` is produced.

## Timing
- Let E0 be the edge at which a mult/div `start` is accepted.
- `busy`=1 in the cycles following E0 through E32 (33 cycles), while the state is RUN or FINISH.
- Iterations execute at edges E1..E32. FINISH registers the result at edge E33.
- `hi`, `lo`, and `done`=1 are visible in the cycle after E33. `busy`=0 in that same cycle.
- Total latency is 34 edges from acceptance to `done`.
- A new `start` may be accepted at E34, back-to-back with the `done` cycle.
- Divide by zero: FINISH at E1; `done` and `div_zero` are visible after E1. `busy` is high for one cycle.
- MTHI/MTLO: register updated at E0; `done` is visible after E0.
- `hi`/`lo` are stable during RUN: they keep their old values until the FINISH edge, so MFHI/MFLO issued during `busy` return the previous result.

## Test plan
- Reset and MTHI/MTLO:
  - Stimulus: assert `reset_n`=0, release it, then MTHI 0x00000006 and MTLO 0x00000006.
  - Required: `hi`=`lo`=0 after reset; `hi`=6 and `lo`=6 after the updates; `busy` never asserts.
- DIVU:
  - Stimulus: `src_a`=0x11111111, `src_b`=0x00000088.
  - Required: after 34 edges, `lo`=0x00202020 and `hi`=0x00000011, with a single `done` pulse.
- MULTU:
  - Stimulus: 0x11111111 × 0x00000088.
  - Required: `hi`=0x00000009 and `lo`=0x11111108. A `start` asserted during `busy` is ignored: the result is unchanged and there is one `done` only.
- Signed operations:
  - DIV −7/2 (0xFFFFFFF9, 0x00000002) → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - MULT −3×5 → {`hi`,`lo`} = 0xFFFFFFFF_FFFFFFF1.
  - MULT 0x80000000² → `hi`=0x40000000, `lo`=0.
- Divide by zero:
  - Stimulus: DIVU 10/0.
  - Required: `done` and `div_zero` after E1; `hi`=10 and `lo`=0xFFFFFFFF. The next MULTU 10×5 clears `div_zero` and gives `lo`=50, `hi`=0.
- Reset mid-operation:
  - Stimulus: assert `reset_n` low at E10 of a MULTU.
  - Required: immediately `busy`=0, `hi`=`lo`=0, and no `done` pulse afterwards.
